// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential MULT/MULTU unit.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        MUL,
        FIX_LO,
        FIX_HI,
        DONE
    } state_t;

    localparam int DEFAULT_BITS = 32;
    localparam int CNT_W        = $clog2(DEFAULT_BITS);

    // Iteration counter width for an arbitrary operand width (never below 1 bit).
    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/mult_sequencer_full_adder.sv
// Ripple-carry adder shared by every arithmetic step of the multiplier.
module FullAdder #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            carry_in,
    output logic [BITS-1:0] sum,
    output logic            carry_out
);

    logic [BITS:0] carry;

    assign carry[0] = carry_in;

    generate
        for (genvar gi = 0; gi < BITS; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry_out = carry[BITS];

endmodule

// File: rtl/mult_sequencer.sv
// Fixed-latency sign-magnitude shift-add multiplier producing a 2*BITS HI/LO product.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] lo,
    output logic            busy
);

    localparam int CNT_BITS = cnt_width(BITS);

    state_t                state_reg;
    logic [BITS-1:0]       mcand_reg;
    logic [BITS-1:0]       hi_reg;
    logic [BITS-1:0]       lo_reg;
    logic [CNT_BITS-1:0]   count_reg;
    logic                  sa_reg;
    logic                  sb_reg;
    logic                  neg_res_reg;
    logic                  cflag_reg;

    logic [BITS-1:0]       add_a;
    logic [BITS-1:0]       add_b;
    logic                  add_cin;
    logic [BITS-1:0]       add_sum;
    logic                  add_carry;

    FullAdder #(.BITS(BITS)) u_add (
        .a         (add_a),
        .b         (add_b),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // Negation is ~x + 1 through the adder; pass-through is x + 0 so every state costs one cycle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_reg)
            NEG_A: begin
                add_a   = sa_reg ? ~mcand_reg : mcand_reg;
                add_cin = sa_reg;
            end
            NEG_B: begin
                add_a   = sb_reg ? ~lo_reg : lo_reg;
                add_cin = sb_reg;
            end
            MUL: begin
                add_a = hi_reg;
                add_b = lo_reg[0] ? mcand_reg : '0;
            end
            FIX_LO: begin
                add_a   = neg_res_reg ? ~lo_reg : lo_reg;
                add_cin = neg_res_reg;
            end
            FIX_HI: begin
                add_a   = neg_res_reg ? ~hi_reg : hi_reg;
                add_cin = neg_res_reg & cflag_reg;
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
        hi        = hi_reg;
        lo        = lo_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            count_reg   <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            neg_res_reg <= 1'b0;
            cflag_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg   <= a;
                        lo_reg      <= b;
                        hi_reg      <= '0;
                        count_reg   <= '0;
                        sa_reg      <= is_signed & a[BITS-1];
                        sb_reg      <= is_signed & b[BITS-1];
                        neg_res_reg <= is_signed & (a[BITS-1] ^ b[BITS-1]);
                        state_reg   <= NEG_A;
                    end
                end
                NEG_A: begin
                    mcand_reg <= add_sum;
                    state_reg <= NEG_B;
                end
                NEG_B: begin
                    lo_reg    <= add_sum;
                    state_reg <= MUL;
                end
                MUL: begin
                    // Multiplier bits shift out of lo as product bits shift in from hi.
                    {hi_reg, lo_reg} <= {add_carry, add_sum, lo_reg[BITS-1:1]};
                    if (count_reg == CNT_BITS'(BITS - 1)) begin
                        count_reg <= '0;
                        state_reg <= FIX_LO;
                    end else begin
                        count_reg <= count_reg + CNT_BITS'(1);
                    end
                end
                FIX_LO: begin
                    lo_reg    <= add_sum;
                    cflag_reg <= add_carry;
                    state_reg <= FIX_HI;
                end
                FIX_HI: begin
                    hi_reg    <= add_sum;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
